// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// slave = cache, master = CPU/memory environment.
interface icache_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] ADDRESS;
  logic [31:0]       INSTRUCTION;
  logic              BUSYWAIT;
  logic              MEM_READ;
  logic [ADDR_W-5:0] MEM_ADDRESS;
  logic [127:0]      MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport slave (
    input  ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 16-byte lines, single-cycle hit.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);
  localparam int unsigned TAG_W = ADDR_W - 4 - INDEX_BITS;
  localparam int unsigned BLK_W = ADDR_W - 4;
  localparam int unsigned LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2,
    S_UNUSED   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [127:0]          data_q [LINES];
  logic [127:0]          fill_buf_q;
  logic [BLK_W-1:0]      mem_addr_q;

  logic [TAG_W-1:0]      addr_tag;
  logic [INDEX_BITS-1:0] addr_idx;
  logic [6:0]            word_base;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;

  assign addr_tag  = bus.ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_idx  = bus.ADDRESS[4 +: INDEX_BITS];
  assign word_base = {bus.ADDRESS[3:2], 5'd0};
  assign fill_idx  = mem_addr_q[INDEX_BITS-1:0];
  assign fill_tag  = mem_addr_q[BLK_W-1 -: TAG_W];
  assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  assign bus.MEM_ADDRESS = mem_addr_q;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (!hit) state_nxt = S_MEM_READ;
      S_MEM_READ: if (!bus.MEM_BUSYWAIT) state_nxt = S_UPDATE;
      S_UPDATE:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs; hit path is combinational from ADDRESS so hits never stall
  always_comb begin
    bus.BUSYWAIT    = 1'b1;
    bus.MEM_READ    = 1'b0;
    bus.INSTRUCTION = 32'h0;
    case (state)
      S_IDLE: begin
        bus.BUSYWAIT = !hit;
        if (hit) bus.INSTRUCTION = data_q[addr_idx][word_base +: 32];
      end
      S_MEM_READ: bus.MEM_READ = 1'b1;
      default: ;
    endcase
  end

  // Miss address latch, fill buffer and line install
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q    <= '0;
      mem_addr_q <= '0;
      fill_buf_q <= '0;
      for (int i = 0; i < int'(LINES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (state == S_IDLE && !hit) mem_addr_q <= bus.ADDRESS[ADDR_W-1:4];
      if (state == S_MEM_READ && !bus.MEM_BUSYWAIT) fill_buf_q <= bus.MEM_READDATA;
      if (state == S_UPDATE) begin
        data_q[fill_idx]  <= fill_buf_q;
        tag_q[fill_idx]   <= fill_tag;
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [ADDR_W-1:0] last_hit_q;
  logic              last_hit_v_q;

  // Saturating counters; a held fetch address counts as one hit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HIT_COUNT    <= 16'h0;
      MISS_COUNT   <= 16'h0;
      last_hit_q   <= '0;
      last_hit_v_q <= 1'b0;
    end else if (state == S_IDLE) begin
      if (hit && (!last_hit_v_q || bus.ADDRESS != last_hit_q)) begin
        if (HIT_COUNT != 16'hFFFF) HIT_COUNT <= HIT_COUNT + 16'd1;
        last_hit_q   <= bus.ADDRESS;
        last_hit_v_q <= 1'b1;
      end
      if (!hit && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: driver issues fetches and queues
// expected instruction/stall, a negedge monitor pops and compares.
module tb_icache;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned INDEX_BITS = 3;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  icache_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  icache #(.ADDR_W(ADDR_W), .INDEX_BITS(INDEX_BITS)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT(hit_count),
    .MISS_COUNT(miss_count)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Instruction memory: fixed contents, L busy cycles per read
  logic [31:0] mem [64][4];
  int lat = 0;
  int mcnt = 0;
  always @(posedge CLK) mcnt <= bus.MEM_READ ? mcnt + 1 : 0;
  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mcnt < lat);
  always_comb begin
    logic [5:0] b;
    b = bus.MEM_ADDRESS;
    bus.MEM_READDATA = {mem[b][3], mem[b][2], mem[b][1], mem[b][0]};
  end

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] instr;
    int          stall;
  } exp_t;
  exp_t sbq[$];

  // Reference model: which block each line holds, plus statistics
  bit         mv [8];
  logic [2:0] mt [8];
  int         n_fill = 0, n_hit = 0;
  logic [9:0] last_hit;
  bit         last_hit_v = 0;
  logic [5:0] exp_blk = '0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mv[i] = 0;
    n_fill = 0; n_hit = 0; last_hit_v = 0;
  endtask

  // Issue one fetch at posedge+1, hold ADDRESS until BUSYWAIT drops
  task automatic fetch(input logic [9:0] a, input int l);
    logic [5:0] blk;
    bit h, done;
    exp_t e;
    blk = a[9:4];
    h = mv[blk[2:0]] && (mt[blk[2:0]] == blk[5:3]);
    lat = l;
    exp_blk = blk;
    bus.ADDRESS = a;
    e.addr = a; e.instr = mem[blk][a[3:2]]; e.stall = h ? 0 : l + 3;
    sbq.push_back(e);
    if (!h) begin mv[blk[2:0]] = 1; mt[blk[2:0]] = blk[5:3]; n_fill++; end
    if (!last_hit_v || last_hit != a) n_hit++;
    last_hit = a; last_hit_v = 1;
    done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!bus.BUSYWAIT) begin done = 1; break; end
    end
    if (!done) begin
      checks++;
      $display("FAIL fetch_timeout: addr %0h still stalled, required completion within 100 cycles", a);
    end
    @(posedge CLK); #1;
  endtask

  // Monitor: one completed fetch per cycle with BUSYWAIT low
  int   busy = 0;
  logic prev_mr = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (RESET || sbq.size() == 0) busy = 0;
    else if (bus.BUSYWAIT) busy++;
    else begin
      e = sbq.pop_front();
      chk($sformatf("instr@%0h", e.addr), bus.INSTRUCTION, e.instr);
      chk($sformatf("stall@%0h", e.addr), 32'(busy), 32'(e.stall));
      busy = 0;
    end
    if (!RESET && bus.MEM_READ && !prev_mr) chk("mem_address", 32'(bus.MEM_ADDRESS), 32'(exp_blk));
    prev_mr = bus.MEM_READ;
  end

  initial begin
    bit seen;
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++) mem[b][w] = $urandom;
    mem[0][0] = 32'h0801_0005;
    model_reset();
    RESET = 1'b1;
    bus.ADDRESS = '0;
    #12;
    chk("rst_busywait", 32'(bus.BUSYWAIT), 32'd1);
    chk("rst_instruction", bus.INSTRUCTION, 32'h0);
    chk("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
    chk("rst_mem_address", 32'(bus.MEM_ADDRESS), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Cold fetch, same-block hits, conflict misses
    fetch(10'h000, 3);
    fetch(10'h004, 3);
    fetch(10'h008, 3);
    fetch(10'h00C, 3);
    fetch(10'h080, 2);
    fetch(10'h080, 2);
    fetch(10'h000, 1);

    // Reset while the fill is in MEM_READ
    lat = 5;
    exp_blk = 6'h10;
    bus.ADDRESS = 10'h100;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.MEM_READ) begin seen = 1; break; end
    end
    chk("midfill_mem_read_seen", 32'(seen), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("midfill_mem_read_drop", 32'(bus.MEM_READ), 32'd0);
    chk("midfill_busywait", 32'(bus.BUSYWAIT), 32'd1);
    model_reset();
    @(posedge CLK); #1;
    RESET = 1'b0;
    fetch(10'h100, 2);
    // Line 0 was invalidated by the reset: zero-latency refill
    fetch(10'h004, 0);
    fetch(10'h104, 0);

    // Randomized fetch stream over a few tags to mix hits and conflicts
    for (int n = 0; n < 300; n++) begin
      logic [9:0] a;
      a = {3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom), 2'($urandom)};
      fetch(a, int'($urandom_range(0, 4)));
    end

`ifdef ICACHE_STATS_EN
    chk("hit_count", 32'(hit_count), 32'(n_hit));
    chk("miss_count", 32'(miss_count), 32'(n_fill));
`endif
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the CPU's PC output and the instruction memory. Each fetch address is looked up in a single cycle. A hit returns the 32-bit instruction with no stall. A miss asserts `BUSYWAIT` to freeze the PC, fetches the whole 16-byte block from instruction memory, installs it, then serves the fetch as a hit.

## Interface
Parameters:
- `ADDR_W`, default 10: fetch address width in bytes. Only `ADDRESS[ADDR_W-1:0]` of the PC is used.
- `INDEX_BITS`, default 3: line index width. The cache has 2^INDEX_BITS lines, 8 by default.

Derived widths (not parameters):
- `TAG_W` = ADDR_W − 4 − INDEX_BITS, which is 3 by default.
- Block address = `ADDR_W`−4 bits.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high.
- `ADDRESS`  in  ADDR_W  byte fetch address from the PC.
- `INSTRUCTION`  out  32  fetched instruction.
- `BUSYWAIT`  out  1  high = CPU must hold the PC and ignore `INSTRUCTION`.
- `MEM_READ`  out  1  block read request to instruction memory.
- `MEM_ADDRESS`  out  ADDR_W−4  block address, equal to `ADDRESS[ADDR_W-1:4]` latched at the miss.
- `MEM_READDATA`  in  128  block returned by memory; word *n* is `[32n+31:32n]`.
- `MEM_BUSYWAIT`  in  1  high while the memory read is in progress.

## Operation
Address split:
- tag = `ADDRESS[ADDR_W-1:4+INDEX_BITS]`
- index = `ADDRESS[3+INDEX_BITS:4]`
- word offset = `ADDRESS[3:2]`
- `ADDRESS[1:0]` is ignored.

Storage per line: a valid bit, a tag of `TAG_W` bits and 128 bits of data.

Hit rule: hit = valid[index] && tag[index] == tag. This is combinational.

`INSTRUCTION`:
- On a hit in IDLE: the selected word of data[index].
- Otherwise: 32'h0.

FSM states:
- IDLE
  - hit: `BUSYWAIT`=0 and the state stays IDLE.
  - miss: `BUSYWAIT`=1 combinationally in the same cycle. On the next edge the block address is latched into `MEM_ADDRESS` and the state goes to MEM_READ.
- MEM_READ
  - `MEM_READ`=1 and `BUSYWAIT`=1.
  - Stays in MEM_READ while `MEM_BUSYWAIT`=1.
  - On the first edge with `MEM_BUSYWAIT`=0, goes to UPDATE.
- UPDATE
  - `MEM_READ`=0 and `BUSYWAIT`=1.
  - On the edge: writes `MEM_READDATA` to data[idx], sets tag[idx] and valid[idx]=1, where idx comes from the latched `MEM_ADDRESS`. Then goes to IDLE.
- States are binary-encoded, 2 bits. The unused encoding goes to IDLE on the next edge with `BUSYWAIT`=1 and `MEM_READ`=0.

Additional rules:
- `MEM_READDATA` is sampled only on the MEM_READ→UPDATE edge. The cache registers it into an internal buffer on that edge and writes the line from the buffer during UPDATE.
- `ADDRESS` changes while the FSM is not in IDLE are ignored. The CPU holds the PC during a stall, and the fill always targets the latched block.
- There are no writes from the CPU side. The cache never writes back.

## Timing
Reset values (asynchronous, while `RESET`=1 and immediately on assertion):
- State is IDLE.
- All valid bits are 0.
- `MEM_READ`=0 and `MEM_ADDRESS`=0.
- Tag and data arrays are 0.
- Because every line is invalid, `BUSYWAIT` is 1 and `INSTRUCTION` is 0 for any `ADDRESS`.

Latencies:
- Hit: 0 cycles, purely combinational from `ADDRESS`.
- Miss stall: let memory hold `MEM_BUSYWAIT` high for L cycles. The stall is 1 cycle in IDLE detecting the miss, plus L+1 cycles in MEM_READ, plus 1 cycle in UPDATE. `BUSYWAIT` falls in the cycle after UPDATE.
- If `MEM_BUSYWAIT` is already 0 on the first MEM_READ cycle, MEM_READ still lasts exactly one cycle.

`MEM_READ` is high from the edge entering MEM_READ to the edge leaving it. It never pulses outside MEM_READ.

Reset asserted mid-fill:
- `MEM_READ` drops asynchronously and the transaction is abandoned.
- The line is not installed. Its valid bit is 0, like every other valid bit.

A conflict miss (same index, different tag) overwrites the line. There is no victim handling.

## Configuration
Macro `ICACHE_STATS_EN`.

When defined:
- Two extra output ports are added: `HIT_COUNT` [15:0] and `MISS_COUNT` [15:0].
- Both reset asynchronously to 0.
- `HIT_COUNT` increments on each edge where the state is IDLE, the access is a hit and `ADDRESS` differs from the previous hit address. Each distinct fetch counts once.
- `MISS_COUNT` increments on each IDLE→MEM_READ transition.
- Both counters saturate at 16'hFFFF.

When undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Cold fetch after reset.** Pulse `RESET`, then apply `ADDRESS`=0x000 with memory latency L=3 and block word0=0x0801_0005 → `BUSYWAIT`=1 and `MEM_READ`=1 with `MEM_ADDRESS`=0x00 for 4 cycles, `INSTRUCTION`=0x0801_0005 with `BUSYWAIT`=0 on cycle 7 after the miss.
- **Same-block hits.** Following that fill, step `ADDRESS` through 0x004, 0x008, 0x00C → words 1, 2, 3 of the block returned with `BUSYWAIT`=0 and no `MEM_READ`.
- **Conflict miss.** Apply 0x080 (same index 0, tag 1) → refill, then hit. Re-apply 0x000 → miss again and refill.
- **Reset mid-fill.** Assert `RESET` during MEM_READ → `MEM_READ`=0 immediately. After release, the same address misses again and refetches.
- **Zero-latency memory.** Hold `MEM_BUSYWAIT`=0 → total stall of 3 cycles and correct word returned.
- **Stats.** With `ICACHE_STATS_EN` defined, run the sequence above → `MISS_COUNT` and `HIT_COUNT` equal the number of fills and distinct hit fetches respectively.
